// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage 16-bit pipeline.
// Produces pipeline-register write enables and NOP-insert flushes, freezes
// the pipe across multi-cycle memory accesses (with timeout), and latches halt.
module pipe_hazard_ctrl #(
  parameter bit          FORWARDING  = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [2:0]  DecRs,
  input  logic [2:0]  DecRt,
  input  logic        DecUseRs,
  input  logic        DecUseRt,
  input  logic [2:0]  D2ERd,
  input  logic        D2ERegWrite,
  input  logic        D2EMemRead,
  input  logic [2:0]  E2MRd,
  input  logic        E2MRegWrite,
  input  logic        BranchTaken,
  input  logic        MemReq,
  input  logic        MemDone,
  input  logic        HaltIn,
  output logic        PCWrite,
  output logic        F2DWrite,
  output logic        F2DFlush,
  output logic        D2EWrite,
  output logic        D2EFlush,
  output logic        E2MWrite,
  output logic        M2WWrite,
  output logic        Halted,
  output logic        MemErr,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_HALT} state_e;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        memerr_q, memerr_d;
  logic [15:0] stall_q;

  logic freeze, match_d2e, match_e2m, data_stall;

  // Source-operand compare against a destination; register 0 is not special.
  function automatic logic src_match(input logic [2:0] rd);
    return (DecUseRs && (DecRs == rd)) || (DecUseRt && (DecRt == rd));
  endfunction

  // Hazard detection: with forwarding only a load in execute forces a bubble.
  always_comb begin
    freeze    = MemReq && !MemDone;
    match_d2e = D2ERegWrite && src_match(D2ERd);
    match_e2m = E2MRegWrite && src_match(E2MRd);
    if (FORWARDING) data_stall = D2EMemRead && match_d2e;
    else            data_stall = match_d2e || match_e2m;
  end

  // Next state and enables; priority halt > freeze > branch > stall > normal.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    memerr_d = memerr_q;
    PCWrite  = 1'b0;
    F2DWrite = 1'b0;
    F2DFlush = 1'b0;
    D2EWrite = 1'b0;
    D2EFlush = 1'b0;
    E2MWrite = 1'b0;
    M2WWrite = 1'b0;
    if (Rst && state_q != S_HALT) begin
      if (freeze) begin
        if (state_q == S_RUN) begin
          state_d = S_MEM_WAIT;
          wcnt_d  = 8'd1;
        end else if (wcnt_q == TIMEOUT) begin
          state_d  = S_HALT;
          memerr_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end else begin
        // Access completed (or none pending): pipe moves this same cycle.
        state_d = (state_q == S_RUN && HaltIn) ? S_HALT : S_RUN;
        wcnt_d  = 8'd0;
        E2MWrite = 1'b1;
        M2WWrite = 1'b1;
        D2EWrite = 1'b1;
        if (BranchTaken) begin
          PCWrite  = 1'b1;
          F2DWrite = 1'b1;
          F2DFlush = 1'b1;
          D2EFlush = 1'b1;
        end else if (data_stall) begin
          D2EFlush = 1'b1;
        end else begin
          PCWrite  = 1'b1;
          F2DWrite = 1'b1;
        end
      end
    end
  end

  // State, wait counter and sticky error registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_RUN;
      wcnt_q   <= 8'd0;
      memerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      memerr_q <= memerr_d;
    end
  end

  // Saturating count of cycles where the PC was held outside of halt.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                                                   stall_q <= 16'd0;
    else if (state_q != S_HALT && !PCWrite && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

  assign Halted     = (state_q == S_HALT);
  assign MemErr     = memerr_q;
  assign StallCount = stall_q;

endmodule
